// File: rtl/comparator_arbiter.sv
// Shared 32-bit magnitude comparator with round-robin request arbitration.
// One operation in flight: accept, compare, then hold the tagged response.
module comparator_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]   req_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_eq,
    output logic              rsp_gr,
    output logic              rsp_lt,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic           op_s;
    logic [IDW-1:0] op_id;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic           accept;
    logic [31:0]    ca;
    logic [31:0]    cb;

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // One-hot ready to the granted requester, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = (state == IDLE) && grant_found;
    assign busy   = (state != IDLE);

    // Flipping the MSB turns the unsigned compare into a signed one
    assign ca = op_a ^ {op_s, 31'b0};
    assign cb = op_b ^ {op_s, 31'b0};

    // Control state, round-robin pointer and latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_s  <= 1'b0;
            op_id <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= req_a[32*grant_id +: 32];
                        op_b  <= req_b[32*grant_id +: 32];
                        op_s  <= req_signed[grant_id];
                        op_id <= grant_id;
                        if (grant_id == IDW'(NREQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= grant_id + IDW'(1);
                        end
                        state <= CMP;
                    end
                end
                CMP: begin
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered, tagged response and completed-operation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_eq    <= 1'b0;
            rsp_gr    <= 1'b0;
            rsp_lt    <= 1'b0;
            op_count  <= '0;
        end else begin
            if (state == CMP) begin
                rsp_eq    <= (ca == cb);
                rsp_gr    <= (ca > cb);
                rsp_lt    <= (ca < cb);
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed plus randomized bench for comparator_arbiter.
// Expected results come from a round-robin/arithmetic reference model.
module tb_comparator_arbiter;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic              rsp_ready;

    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic              rsp_eq;
    logic              rsp_gr;
    logic              rsp_lt;
    logic              busy;
    logic [15:0]       op_count;

    logic [NREQ-1:0]   req_ready4;
    logic              rsp_valid4;
    logic [1:0]        rsp_id4;
    logic              rsp_eq4;
    logic              rsp_gr4;
    logic              rsp_lt4;
    logic              busy4;
    logic [3:0]        op_count4;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int m_cnt = 0;

    comparator_arbiter #(.NREQ(NREQ), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_eq(rsp_eq), .rsp_gr(rsp_gr), .rsp_lt(rsp_lt),
        .busy(busy), .op_count(op_count)
    );

    comparator_arbiter #(.NREQ(NREQ), .CNTW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
        .rsp_eq(rsp_eq4), .rsp_gr(rsp_gr4), .rsp_lt(rsp_lt4),
        .busy(busy4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // {eq, gr, lt} from plain integer comparison
    function automatic logic [2:0] ref_cmp(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic s);
        longint x;
        longint y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        return {x == y, x > y, x < y};
    endfunction

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_signed[i]     = s;
        req_valid[i]      = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full operation from IDLE; entered and left at posedge+1
    task automatic serve(input int stall, input bit keep);
        int g;
        logic [2:0] e;
        logic [1:0] gid;
        g = pick(req_valid);
        check("grant", 64'(req_ready), 64'(oh(g)));
        check("idle_busy", 64'(busy), 64'd0);
        if (g < 0) begin
            step();
            return;
        end
        gid = 2'(g);
        e = ref_cmp(req_a[32*g +: 32], req_b[32*g +: 32], req_signed[g]);
        step();
        m_ptr = (g + 1) % NREQ;
        if (!keep) req_valid[g] = 1'b0;
        check("cmp_busy", 64'(busy), 64'd1);
        check("cmp_ready", 64'(req_ready), 64'd0);
        check("cmp_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(gid));
        check("rsp_flags", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'(e));
        for (int i = 0; i < stall; i++) begin
            step();
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_id", 64'(rsp_id), 64'(gid));
            check("hold_flags", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'(e));
            check("hold_ready", 64'(req_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        m_cnt++;
        check("done_valid", 64'(rsp_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("done_count", 64'(op_count), 64'(m_cnt % 65536));
        check("done_count4", 64'(op_count4), 64'(m_cnt % 16));
        check("done_keep", 64'({rsp_id, rsp_eq, rsp_gr, rsp_lt}),
              64'({gid, e}));
        check("next_ready", 64'(req_ready), 64'(oh(pick(req_valid))));
        check("dut4_mirror",
              64'({rsp_valid4, rsp_id4, rsp_eq4, rsp_gr4, rsp_lt4,
                   busy4, req_ready4}),
              64'({1'b0, gid, e, 1'b0, oh(pick(req_valid))}));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n      = 1'b0;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        rsp_ready  = 1'b0;

        // reset state
        #12;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp",
              64'({rsp_valid, rsp_id, rsp_eq, rsp_gr, rsp_lt}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(op_count), 64'd0);
        check("rst_count4", 64'(op_count4), 64'd0);

        // round robin with all requesters valid from reset
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'(i * 7 + 1), 32'd8, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        check("rr_first_accepted", 64'(busy), 64'd1);
        step();
        check("rr_first_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        m_ptr = 1;
        m_cnt = 1;
        for (int n = 0; n < 4; n++) serve(0, 1'b1);
        check("rr_wrap_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        #1;

        // unsigned 5 > 3 on requester 0 regardless of ptr
        set_req(0, 32'h5, 32'h3, 1'b0);
        #1;
        serve(0, 1'b0);
        check("u_gr", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'b010);

        // signed vs unsigned on the same operands
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b1);
        #1;
        serve(0, 1'b0);
        check("s_lt", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'b001);
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1;
        serve(0, 1'b0);
        check("u_gr2", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'b010);
        set_req(3, 32'h8000_0000, 32'h8000_0000, 1'b1);
        #1;
        serve(0, 1'b0);
        check("s_eq", 64'({rsp_eq, rsp_gr, rsp_lt}), 64'b100);

        // backpressure with two requesters pending
        set_req(1, 32'h10, 32'h20, 1'b0);
        set_req(2, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
        #1;
        serve(5, 1'b0);
        serve(0, 1'b0);

        // withdrawn request is not granted and ptr stays put
        set_req(0, 32'h1, 32'h1, 1'b0);
        #1;
        check("wd_ready", 64'(req_ready), 64'b0001);
        req_valid = '0;
        step();
        check("wd_busy", 64'(busy), 64'd0);
        set_req(0, 32'h9, 32'h2, 1'b0);
        set_req(3, 32'h2, 32'h9, 1'b0);
        #1;
        serve(0, 1'b0);
        serve(0, 1'b0);

        // reset while in CMP discards the operation
        set_req(2, 32'h3, 32'h4, 1'b0);
        #1;
        check("mid_ready", 64'(req_ready), 64'b0100);
        step();
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        m_cnt = 0;
        m_ptr = 0;
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_busy_clr", 64'(busy), 64'd0);
        check("mid_count", 64'(op_count), 64'd0);
        check("mid_ready_clr", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("no_stale", 64'({rsp_valid, busy}), 64'd0);
            step();
        end
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'(i), 32'd1, 1'b0);
        end
        #1;
        serve(0, 1'b0);
        req_valid = '0;
        #1;

        // randomized traffic, long enough to wrap the 4-bit counter
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    set_req(i, ra, rb, 1'($urandom_range(0, 1)));
                end
            end
            if (req_valid == '0) begin
                ra = $urandom;
                set_req(int'($urandom_range(0, NREQ - 1)), ra, ~ra,
                        1'($urandom_range(0, 1)));
            end
            #1;
            serve(int'($urandom_range(0, 2)), 1'b0);
        end
        check("wrap_count4", 64'(op_count4), 64'(m_cnt % 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_arbiter.md
Name: comparator_arbiter

Overview:
- Shares one 32-bit magnitude comparator datapath (Eq/Gr/Lt) among NREQ requesters inside the CORDIC processor, e.g. the angle-compare, quadrant-fold and convergence-check units.
- Uses round-robin arbitration with valid/ready request channels.
- Optional per-request signed compare via MSB flip.
- Registered operands and result; single response channel tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID tag.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*32  operand A, requester i at [32*i+31:32*i].
- req_b  in  NREQ*32  operand B, same packing.
- req_signed  in  NREQ  1 = two's-complement compare, 0 = unsigned.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  IDW  requester index of the result.
- rsp_eq  out  1  A == B.
- rsp_gr  out  1  A > B.
- rsp_lt  out  1  A < B.
- busy  out  1  state != IDLE.
- op_count  out  CNTW  completed responses; wraps modulo 2^CNTW.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, operand/ID registers=0.
  - rsp_valid=0, rsp_id=0, rsp_eq=rsp_gr=rsp_lt=0, busy=0, op_count=0.
  - req_ready=0 while in reset.
  - Reset mid-operation discards the in-flight request and result; no response is issued.
- States:
  - IDLE:
    - Grant g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
    - req_ready[g]=1 combinationally; all other bits 0; all 0 if no valid.
    - On the edge where req_valid[g]&req_ready[g]: latch op_a=req_a[g], op_b=req_b[g], op_s=req_signed[g], op_id=g; set ptr<=(g+1) mod NREQ; go to CMP.
  - CMP:
    - Comparator inputs: ca=op_a^{op_s,31'b0}, cb=op_b^{op_s,31'b0} (MSB flip makes the unsigned compare equal the signed compare).
    - On the next edge: rsp_eq/gr/lt <= comparator outputs, rsp_id<=op_id, rsp_valid<=1; go to RESP.
  - RESP:
    - Hold all rsp_* stable while rsp_ready=0.
    - On the edge with rsp_valid&rsp_ready: rsp_valid<=0, op_count<=op_count+1; go to IDLE.
    - rsp_eq/gr/lt/id keep their last values after rsp_valid drops.
- Latency and throughput:
  - rsp_valid rises exactly 1 cycle after the accepting edge.
  - Minimum 3 cycles per operation (accept, compare, response handshake); no overlap.
  - The next req_ready is asserted no earlier than the cycle after the response handshake.
- Invariants:
  - When rsp_valid=1, exactly one of rsp_eq, rsp_gr, rsp_lt is 1.
  - req_ready is zero outside IDLE.
  - ptr only changes on a grant handshake.
- Requester rules:
  - Hold req_a, req_b, req_signed stable while req_valid=1 and not yet accepted.
  - A request withdrawn before acceptance is simply not granted; ptr is unchanged.
- Boundaries:
  - ptr wraps NREQ-1 -> 0.
  - Single active requester is granted every time regardless of ptr.
  - op_count wraps 2^CNTW-1 -> 0.
  - req_valid arriving while busy waits; no request is lost or duplicated.

Test Plan:
- Unsigned: req0 a=0x00000005, b=0x00000003, signed=0 -> accepted, rsp_valid 1 cycle later, rsp_id=0, gr=1, eq=0, lt=0; op_count=1 after handshake.
- Signed vs unsigned: a=0xFFFFFFFF, b=0x00000001; signed=1 -> lt=1; same operands with signed=0 -> gr=1. Also a=b=0x80000000, signed=1 -> eq=1.
- Round-robin: all 4 requesters valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0; ptr wraps; each response 3 cycles apart with correct rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles with req1, req2 pending -> rsp_* held stable, req_ready all 0, busy=1; release -> next grant goes to the correct requester.
- Reset mid-op: assert rst_n=0 in CMP -> rsp_valid=0, busy=0, ptr=0, op_count=0 immediately; no stale response after release.
- Counter wrap (CNTW=4 variant): complete 17 operations -> op_count=1.
